// File: rtl/turn_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : turn_signal_sequencer
// Brief    : Debounced stalk/hazard inputs feeding a blink FSM with normal,
//            comfort (tap) and latched hazard modes, plus a piezo click pulse.
// Revision : 1.0
// ============================================================================
module turn_signal_sequencer #(
  parameter int HALF_PERIOD    = 5_000_000,
  parameter int DEBOUNCE       = 100_000,
  parameter int TAP_MAX        = 10_000_000,
  parameter int COMFORT_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_turn_left,
  input  logic       sw_turn_right,
  input  logic       btn_hazard,
  output logic       turn_left,
  output logic       turn_right,
  output logic       click,
  output logic [2:0] state_dbg
);

  localparam int PH_W   = $clog2(HALF_PERIOD);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = (TAP_MAX < 1) ? 1 : $clog2(TAP_MAX + 1);
  localparam int ON_W   = $clog2(COMFORT_BLINKS + 1);

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [DB_W-1:0]   DB_LIMIT = DB_W'(DEBOUNCE);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(TAP_MAX);
  localparam logic [ON_W-1:0]   ON_SAT   = ON_W'(COMFORT_BLINKS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LEFT      = 3'd1;
  localparam logic [2:0] S_RIGHT     = 3'd2;
  localparam logic [2:0] S_COMFORT_L = 3'd3;
  localparam logic [2:0] S_COMFORT_R = 3'd4;
  localparam logic [2:0] S_HAZARD    = 3'd5;

  logic [2:0]        raw_in;
  logic [1:0]        sw_deb;
  logic              hazard_latched;

  logic [2:0]        state;
  logic [2:0]        state_n;
  logic              phase_on;
  logic              phase_n;
  logic [PH_W-1:0]   phase_cnt;
  logic [PH_W-1:0]   phase_cnt_n;
  logic [ON_W-1:0]   on_cnt;
  logic [ON_W-1:0]   on_cnt_n;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_n;

  logic              l_only;
  logic              r_only;
  logic              both;
  logic              wrap;
  logic              comfort_done;
  logic              restart;
  logic              click_n;

  assign raw_in = {btn_hazard, sw_turn_right, sw_turn_left};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_input
      logic            sync1;
      logic            sync2;
      logic            deb_q;
      logic [DB_W-1:0] db_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1  <= 1'b0;
          sync2  <= 1'b0;
          deb_q  <= 1'b0;
          db_cnt <= '0;
        end else begin
          sync1 <= raw_in[i];
          sync2 <= sync1;
          if (sync2 != deb_q) begin
            if (db_cnt == DB_LIMIT) begin
              deb_q  <= sync2;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
          end
        end
      end

      if (i < 2) begin : g_switch
        assign sw_deb[i] = deb_q;
      end else begin : g_hazard_latch
        // Toggle on the same edge the debounced button goes high.
        always_ff @(posedge clk) begin
          if (rst) begin
            hazard_latched <= 1'b0;
          end else if (sync2 && !deb_q && (db_cnt == DB_LIMIT)) begin
            hazard_latched <= ~hazard_latched;
          end
        end
      end
    end
  endgenerate

  assign l_only = sw_deb[0] & ~sw_deb[1];
  assign r_only = sw_deb[1] & ~sw_deb[0];
  assign both   = sw_deb[0] &  sw_deb[1];

  assign wrap         = (phase_cnt == PH_LAST);
  assign comfort_done = (on_cnt >= ON_SAT) && (!phase_on || wrap);

  always_comb begin
    state_n = state;
    if (hazard_latched) begin
      state_n = S_HAZARD;
    end else begin
      case (state)
        S_HAZARD: begin
          if (l_only)      state_n = S_LEFT;
          else if (r_only) state_n = S_RIGHT;
          else             state_n = S_IDLE;
        end
        S_IDLE: begin
          if (l_only)      state_n = S_LEFT;
          else if (r_only) state_n = S_RIGHT;
        end
        S_LEFT: begin
          if (both)            state_n = S_IDLE;
          else if (r_only)     state_n = S_RIGHT;
          else if (!sw_deb[0]) state_n = (hold_cnt < HOLD_SAT) ? S_COMFORT_L : S_IDLE;
        end
        S_RIGHT: begin
          if (both)            state_n = S_IDLE;
          else if (l_only)     state_n = S_LEFT;
          else if (!sw_deb[1]) state_n = (hold_cnt < HOLD_SAT) ? S_COMFORT_R : S_IDLE;
        end
        S_COMFORT_L: begin
          if (r_only)            state_n = S_RIGHT;
          else if (l_only)       state_n = S_LEFT;
          else if (comfort_done) state_n = S_IDLE;
        end
        S_COMFORT_R: begin
          if (l_only)            state_n = S_LEFT;
          else if (r_only)       state_n = S_RIGHT;
          else if (comfort_done) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Returning from comfort to the same side keeps the running blink.
  assign restart = (state_n == S_LEFT || state_n == S_RIGHT || state_n == S_HAZARD)
                && (state_n != state)
                && !((state == S_COMFORT_L) && (state_n == S_LEFT))
                && !((state == S_COMFORT_R) && (state_n == S_RIGHT));

  always_comb begin
    phase_cnt_n = wrap ? '0 : phase_cnt + 1'b1;
    phase_n     = phase_on ^ wrap;
    on_cnt_n    = on_cnt;
    if (wrap && !phase_on && (on_cnt < ON_SAT)) begin
      on_cnt_n = on_cnt + 1'b1;
    end
    if (state_n == S_IDLE) begin
      phase_cnt_n = '0;
      phase_n     = 1'b0;
      on_cnt_n    = '0;
    end else if (restart) begin
      phase_cnt_n = '0;
      phase_n     = 1'b1;
      on_cnt_n    = ON_W'(1);
    end
  end

  always_comb begin
    hold_cnt_n = '0;
    if (state_n == S_LEFT || state_n == S_RIGHT) begin
      if (state_n != state) begin
        hold_cnt_n = '0;
      end else if (hold_cnt != HOLD_SAT) begin
        hold_cnt_n = hold_cnt + 1'b1;
      end else begin
        hold_cnt_n = hold_cnt;
      end
    end
  end

  assign click_n = (state_n != S_IDLE) && (restart || wrap);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_on   <= 1'b0;
      phase_cnt  <= '0;
      on_cnt     <= '0;
      hold_cnt   <= '0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      click      <= 1'b0;
    end else begin
      state      <= state_n;
      phase_on   <= phase_n;
      phase_cnt  <= phase_cnt_n;
      on_cnt     <= on_cnt_n;
      hold_cnt   <= hold_cnt_n;
      turn_left  <= phase_n && (state_n == S_LEFT  || state_n == S_COMFORT_L || state_n == S_HAZARD);
      turn_right <= phase_n && (state_n == S_RIGHT || state_n == S_COMFORT_R || state_n == S_HAZARD);
      click      <= click_n;
    end
  end

  assign state_dbg = state;

endmodule
`default_nettype wire
